nmea_sentence_checker: RTL and testbench

Sits between the UART receiver and the GPS sentence parser. It frames NMEA sentences from the received byte stream, checks the XOR checksum and the hex digits, and buffers each sentence. Only sentences that pass are replayed downstream as a burst of byte strobes, in the same valid-strobe format the parser already accepts. Malformed sentences never reach the parser, and good/bad sentences are counted for debug readout.

---
 rtl/nmea_pkg.sv | 17 +
 rtl/nmea_sentence_buf.sv | 20 ++
 rtl/nmea_sentence_checker.sv | 165 ++++++++++++++++
 tb/tb_nmea_sentence_checker.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/nmea_pkg.sv
// nmea_pkg: shared constants, state encoding and hex digit decode for the NMEA checker.
package nmea_pkg;
  localparam logic [7:0] DOLLAR = 8'h24;
  localparam logic [7:0] STAR = 8'h2A;
  localparam logic [1:0] ERR_CKSUM = 2'd0;
  localparam logic [1:0] ERR_BADHEX = 2'd1;
  localparam logic [1:0] ERR_OVERLEN = 2'd2;
  localparam logic [1:0] ERR_RESTART = 2'd3;
  typedef enum logic [2:0] {IDLE, BODY, CK_HI, CK_LO, CHECK, REPLAY} state_e;
  // Folding bit 5 maps 'A'-'F' onto 'a'-'f' so one range test covers both cases.
  function automatic logic [4:0] hex_nibble(input logic [7:0] c);
    logic [7:0] lc;
    lc = c | 8'h20;
    return (c >= 8'h30 && c <= 8'h39) ? {1'b1, c[3:0]} :
           (lc >= 8'h61 && lc <= 8'h66) ? {1'b1, c[3:0] + 4'd9} : 5'd0;
  endfunction
endpackage

// File: rtl/nmea_sentence_buf.sv
// nmea_sentence_buf: MAX_LEN x 8 simple dual-port RAM with a registered read port.
module nmea_sentence_buf #(
  parameter int MAX_LEN = 82,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [MAX_LEN];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= 8'h00;
    else rdata <= mem[raddr];
endmodule

// File: rtl/nmea_sentence_checker.sv
// nmea_sentence_checker: frames NMEA sentences, verifies hex checksum, replays only good ones.
module nmea_sentence_checker
  import nmea_pkg::*;
#(
  parameter int MAX_LEN = 82,
  parameter int AW = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);
  state_e state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, len_q, len_d, rptr_q, rptr_d, waddr;
  logic [7:0] acc_q, acc_d;
  logic [3:0] hi_q, hi_d, lo_q, lo_d;
  logic [1:0] code_q, code_d;
  logic [15:0] good_q, bad_q;
  logic ok_q, ok_d, err_q, err_d, vld_q, vld_d, sof_q, sof_d, eof_q, eof_d, we;
  logic [4:0] hx;
  logic dol, star, ovf;
  assign hx = hex_nibble(in_data);
  assign dol = in_data == DOLLAR;
  assign star = in_data == STAR;
  assign ovf = wptr_q == AW'(MAX_LEN);
  always_comb begin
    state_d = state_q;
    wptr_d = wptr_q;
    acc_d = acc_q;
    hi_d = hi_q;
    lo_d = lo_q;
    len_d = len_q;
    rptr_d = rptr_q;
    we = 1'b0;
    waddr = wptr_q;
    ok_d = 1'b0;
    err_d = 1'b0;
    code_d = code_q;
    vld_d = 1'b0;
    sof_d = 1'b0;
    eof_d = 1'b0;
    case (state_q)
      IDLE: if (in_valid && dol) begin
        we = 1'b1;
        waddr = '0;
        wptr_d = AW'(1);
        acc_d = 8'h00;
        state_d = BODY;
      end
      BODY, CK_HI, CK_LO: if (in_valid) begin
        if (ovf) begin
          err_d = 1'b1;
          code_d = ERR_OVERLEN;
          state_d = IDLE;
        end else if (dol) begin
          // A '$' anywhere inside a frame aborts it and opens the next one in the same cycle.
          err_d = 1'b1;
          code_d = state_q == BODY ? ERR_RESTART : ERR_BADHEX;
          we = 1'b1;
          waddr = '0;
          wptr_d = AW'(1);
          acc_d = 8'h00;
          state_d = BODY;
        end else begin
          we = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (state_q == BODY) begin
            acc_d = star ? acc_q : acc_q ^ in_data;
            state_d = star ? CK_HI : BODY;
          end else if (!hx[4]) begin
            err_d = 1'b1;
            code_d = ERR_BADHEX;
            state_d = IDLE;
          end else if (state_q == CK_HI) begin
            hi_d = hx[3:0];
            state_d = CK_LO;
          end else begin
            lo_d = hx[3:0];
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        ok_d = {hi_q, lo_q} == acc_q;
        err_d = !ok_d || (in_valid && dol);
        code_d = !ok_d ? ERR_CKSUM : (in_valid && dol) ? ERR_RESTART : code_q;
        len_d = wptr_q;
        rptr_d = '0;
        state_d = ok_d ? REPLAY : IDLE;
      end
      REPLAY: begin
        vld_d = 1'b1;
        sof_d = rptr_q == '0;
        eof_d = rptr_q == len_q - 1'b1;
        rptr_d = rptr_q + 1'b1;
        state_d = eof_d ? IDLE : REPLAY;
        err_d = in_valid && dol;
        code_d = err_d ? ERR_RESTART : code_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      wptr_q <= '0;
      len_q <= '0;
      rptr_q <= '0;
      acc_q <= 8'h00;
      hi_q <= 4'h0;
      lo_q <= 4'h0;
      code_q <= 2'd0;
      ok_q <= 1'b0;
      err_q <= 1'b0;
      vld_q <= 1'b0;
      sof_q <= 1'b0;
      eof_q <= 1'b0;
      good_q <= 16'h0;
      bad_q <= 16'h0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      len_q <= len_d;
      rptr_q <= rptr_d;
      acc_q <= acc_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      code_q <= code_d;
      ok_q <= ok_d;
      err_q <= err_d;
      vld_q <= vld_d;
      sof_q <= sof_d;
      eof_q <= eof_d;
      if (ok_d && !(&good_q)) good_q <= good_q + 16'd1;
      if (err_d && !(&bad_q)) bad_q <= bad_q + 16'd1;
    end
  nmea_sentence_buf #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
    .clk(clk),
    .rst(rst),
    .we(we),
    .waddr(waddr),
    .wdata(in_data),
    .raddr(rptr_q),
    .rdata(out_data)
  );
  assign out_valid = vld_q;
  assign out_sof = sof_q;
  assign out_eof = eof_q;
  assign frame_ok = ok_q;
  assign frame_err = err_q;
  assign err_code = code_q;
  assign busy = state_q != IDLE;
  assign good_cnt = good_q;
  assign bad_cnt = bad_q;
endmodule

// File: tb/tb_nmea_sentence_checker.sv
// tb_nmea_sentence_checker: directed scoreboard bench; expected beats/events carry their due clock edge.
module tb_nmea_sentence_checker;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0;
  logic [7:0] out_data;
  logic out_valid, out_sof, out_eof, frame_ok, frame_err, busy;
  logic [1:0] err_code;
  logic [15:0] good_cnt, bad_cnt;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mg = 0;
  int mb = 0;
  logic [41:0] bq[$];
  logic [34:0] eq[$];

  always #5 clk = ~clk;

  nmea_sentence_checker dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy),
    .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data = d;
    @(posedge clk);
    cyc++;
    #1;
    in_valid = 1'b0;
    if (out_valid) begin
      if (bq.size() == 0) chk("spurious_beat", 64'(out_valid), 64'd0);
      else chk("beat", 64'({32'(cyc), out_data, out_sof, out_eof}), 64'(bq.pop_front()));
    end
    if (frame_ok || frame_err) begin
      if (eq.size() == 0) chk("spurious_event", 64'({frame_ok, frame_err}), 64'd0);
      else chk("event", 64'({32'(cyc), frame_ok ? 3'b100 : {1'b0, err_code}}), 64'(eq.pop_front()));
    end
  endtask

  // kind 4 = frame_ok, 0..3 = frame_err with that code; due at edge cyc+dt.
  task automatic exp_ev(input logic [2:0] kind, input int dt);
    eq.push_back({32'(cyc + dt), kind});
    if (kind == 3'd4) mg++;
    else mb++;
  endtask

  task automatic send(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      step(1'b1, s[i]);
      repeat (gap) step(1'b0, 8'h00);
    end
  endtask

  task automatic good(input string s, input int gap, input int inj);
    for (int i = 0; i < s.len() - 1; i++) begin
      step(1'b1, s[i]);
      repeat (gap) step(1'b0, 8'h00);
    end
    exp_ev(3'd4, 2);
    for (int i = 0; i < s.len(); i++)
      bq.push_back({32'(cyc + 3 + i), 8'(s[i]), i == 0, i == s.len() - 1});
    step(1'b1, s[s.len() - 1]);
    if (inj > 0) begin
      repeat (inj) step(1'b0, 8'h00);
      exp_ev(3'd3, 1);
      step(1'b1, 8'h24);
    end
    repeat (s.len() + 4) step(1'b0, 8'h00);
  endtask

  task automatic drained(input string tag);
    chk({tag, "_beats_left"}, 64'(bq.size()), 64'd0);
    chk({tag, "_events_left"}, 64'(eq.size()), 64'd0);
    chk({tag, "_good_cnt"}, 64'(good_cnt), 64'(mg));
    chk({tag, "_bad_cnt"}, 64'(bad_cnt), 64'(mb));
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sof_eof", 64'({out_sof, out_eof}), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_ok_err", 64'({frame_ok, frame_err}), 64'd0);
    chk("rst_err_code", 64'(err_code), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_counters", 64'({good_cnt, bad_cnt}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    step(1'b0, 8'h00);
    step(1'b1, 8'h41);
    chk("idle_ignores", 64'(busy), 64'd0);

    good("$A*41", 870, 0);
    drained("slow");

    good("$AB*03", 2, 0);
    send("$AB*0", 2);
    exp_ev(3'd0, 2);
    send("4", 10);
    drained("cksum");
    chk("cksum_code", 64'(err_code), 64'd0);

    send("$AB*0", 2);
    exp_ev(3'd1, 1);
    send("G", 10);
    drained("badhex");
    chk("badhex_code", 64'(err_code), 64'd1);

    send("$A*4", 2);
    exp_ev(3'd1, 1);
    good("$A*41", 2, 0);
    drained("badhex_dollar");

    send("$AB", 2);
    exp_ev(3'd3, 1);
    good("$A*41", 2, 0);
    drained("restart");
    chk("restart_code", 64'(err_code), 64'd3);

    step(1'b1, 8'h24);
    for (int i = 0; i < 81; i++) step(1'b1, 8'h41);
    chk("full_busy", 64'(busy), 64'd1);
    exp_ev(3'd2, 1);
    step(1'b1, 8'h41);
    chk("overlen_idle", 64'(busy), 64'd0);
    chk("overlen_code", 64'(err_code), 64'd2);
    good("$A*41", 1, 0);
    drained("overlen");

    good("$AB*03", 1, 2);
    drained("inject");
    chk("inject_code", 64'(err_code), 64'd3);

    send("$A*4", 1);
    exp_ev(3'd4, 2);
    bq.push_back({32'(cyc + 3), 8'h24, 1'b1, 1'b0});
    bq.push_back({32'(cyc + 4), 8'h41, 1'b0, 1'b0});
    step(1'b1, 8'h31);
    repeat (3) step(1'b0, 8'h00);
    rst = 1'b1;
    mg = 0;
    mb = 0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    repeat (2) step(1'b0, 8'h00);
    rst = 1'b0;
    repeat (10) step(1'b0, 8'h00);
    drained("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
